i2s_rx_multi: RTL and testbench
===============================

# i2s_rx_multi

Parametrised multi-line I2S receive master for the Hazard2 SoC. It generates the I2S bit clock (`sck`) and word select (`ws`) from `HCLK`, and deserialises NUM_LINES serial data inputs in parallel. Captured samples are tagged with line index and channel, then queued in a first-word-fall-through FIFO read by the SoC over a valid/ready handshake. It supersedes the fixed two-bit I2S path, adding configurable width, line count and clock ratio, a mono mode, buffering and overflow reporting.

## Interface
- NUM_LINES, 2: number of parallel serial data inputs (1..8).
- SAMPLE_W, 24: captured bits per sample, MSB first.
- SLOT_W, 32: sck cycles per channel slot; requires SLOT_W ≥ SAMPLE_W+1.
- CLK_DIV, 2: HCLK cycles per sck half-period (≥1).
- FIFO_DEPTH, 8: FIFO entries, power of 2.
- Constraint: NUM_LINES ≤ 2·CLK_DIV·(SLOT_W−SAMPLE_W).

Ports:
- HCLK  in  1  system clock; all logic rising-edge.
- HRESET  in  1  synchronous, active-high reset.
- en  in  1  receiver enable.
- mono  in  1  1 = push left-slot samples only.
- sd_in  in  NUM_LINES  serial data, one bit per line.
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sample_data  out  SAMPLE_W  FIFO head sample.
- sample_line  out  max(1,clog2(NUM_LINES))  FIFO head line index.
- sample_right  out  1  FIFO head channel.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  pop the head when it is valid.
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; set when a sample is dropped.
- overflow_clr  in  1  clears overflow.

## Operation
- Reset values:
  - sck=0, ws=0.
  - Divider, bit and push counters = 0.
  - FIFO empty, so sample_valid=0 and level=0.
  - overflow=0; data outputs = 0.
- Clock generation:
  - The divider counts 0..CLK_DIV−1 while en=1.
  - On the terminal count, sck toggles.
  - "Rise event" = the HCLK cycle in which sck goes 0→1; "fall event" = 1→0.
- Bit counter `bc` (0..SLOT_W−1):
  - Increments on each fall event and wraps at SLOT_W.
  - On the wrap, ws toggles in the same cycle, so ws changes on the sck falling edge.
- Capture, per rise event at slot bit index `bc`:
  - bc=0: I2S delay bit, ignored.
  - bc=1..SAMPLE_W: sd_in[i] shifts into shift register i, MSB first.
  - bc > SAMPLE_W: ignored.
- Push:
  - On the rise event with bc=SAMPLE_W, all shift registers copy to shadow registers, along with the current ws.
  - Over the next NUM_LINES HCLK cycles, the push sequencer writes lines 0..NUM_LINES−1 in order, one per cycle.
  - Each entry is {data, line, ws}.
  - If mono=1 and ws=1, no push occurs.
- FIFO behaviour:
  - Pop when sample_valid & sample_ready.
  - If full, a push is accepted only if a pop happens in the same cycle; level stays unchanged.
  - Otherwise a push when full drops the entry and sets overflow.
  - Simultaneous overflow set and overflow_clr: set wins.
- en low:
  - sck, ws and all counters clear to 0 on the next edge.
  - A partial slot is discarded and a pending push sequence is aborted.
  - FIFO contents and overflow are retained, and pops continue.
  - Re-enabling starts a fresh left slot.
- Arithmetic: all counters wrap modulo their range; level never exceeds FIFO_DEPTH.

## Timing
- sck period = 2·CLK_DIV HCLK cycles; frame = 2·SLOT_W sck periods.
- First rise event occurs CLK_DIV cycles after en rises.
- Shadow capture happens at edge T. Line k is written at edge T+1+k, and line 0 is visible with sample_valid=1 after edge T+1.
- Pop takes effect at the edge; the next head is presented in the following cycle.
- HRESET mid-operation: all state returns to reset values at that edge, including FIFO flush.

## Test plan
- Reset: assert HRESET for 2 cycles with en=1 mid-frame -> sck=0, ws=0, sample_valid=0, level=0, overflow=0 on the next cycle.
- Stereo capture, defaults (CLK_DIV=2): line0 L=0xA5A5A5, R=0x5A5A5A; line1 L=0x123456, R=0xFEDCBA; sample_ready=1.
  - Expected FIFO order: {0xA5A5A5,0,0}, {0x123456,1,0}, {0x5A5A5A,0,1}, {0xFEDCBA,1,1}.
  - sck period 4 cycles; ws period 256 cycles.
- Mono: same stimulus with mono=1 -> only the two left entries appear each frame; level peaks at 2 with ready=0.
- Overflow: ready=0, FIFO_DEPTH=8, run 3 stereo frames.
  - level=8; overflow=1 after the 9th push attempt.
  - Head remains line0 left of frame 1.
  - Pulse overflow_clr -> overflow=0. Assert overflow_clr during a drop -> overflow stays 1.
- Enable abort: drop en at bc=10 of the left slot -> sck=0, ws=0 next cycle, no entry pushed. Re-enable -> first entry is the next full left sample.
- Full with pop: FIFO full with ready=1 at a push cycle -> entry accepted, level stays 8, overflow stays 0.

Source files
------------

// File: rtl/i2s_rx_multi.sv
// Multi-line I2S receive master: generates sck/ws, deserialises NUM_LINES inputs
// and queues tagged samples in a first-word-fall-through FIFO.
module i2s_rx_multi #(
  parameter int NUM_LINES  = 2,
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                              HCLK,
  input  logic                                              HRESET,
  input  logic                                              en,
  input  logic                                              mono,
  input  logic [NUM_LINES-1:0]                              sd_in,
  output logic                                              sck,
  output logic                                              ws,
  output logic [SAMPLE_W-1:0]                               sample_data,
  output logic [((NUM_LINES > 1) ? $clog2(NUM_LINES) : 1)-1:0] sample_line,
  output logic                                              sample_right,
  output logic                                              sample_valid,
  input  logic                                              sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]                       level,
  output logic                                              overflow,
  input  logic                                              overflow_clr
);

  localparam int LINE_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W    = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = SAMPLE_W + LINE_W + 1;

  logic [DIV_W-1:0] div_reg;
  logic [BC_W-1:0]  bc_reg;
  logic             sck_reg;
  logic             ws_reg;
  logic             div_tc;
  logic             rise;
  logic             fall;
  logic             capture_bit;
  logic             capture_last;

  assign div_tc       = (div_reg == DIV_W'(CLK_DIV - 1));
  assign rise         = en && div_tc && !sck_reg;
  assign fall         = en && div_tc && sck_reg;
  assign capture_bit  = rise && (bc_reg != '0) && (bc_reg <= BC_W'(SAMPLE_W));
  assign capture_last = rise && (bc_reg == BC_W'(SAMPLE_W));

  // ws toggles together with the bit-counter wrap, i.e. on the sck falling edge.
  always_ff @(posedge HCLK) begin
    if (HRESET || !en) begin
      div_reg <= '0;
      bc_reg  <= '0;
      sck_reg <= 1'b0;
      ws_reg  <= 1'b0;
    end else begin
      div_reg <= div_tc ? '0 : div_reg + 1'b1;
      if (div_tc) begin
        sck_reg <= !sck_reg;
      end
      if (fall) begin
        if (bc_reg == BC_W'(SLOT_W - 1)) begin
          bc_reg <= '0;
          ws_reg <= !ws_reg;
        end else begin
          bc_reg <= bc_reg + 1'b1;
        end
      end
    end
  end

  assign sck = sck_reg;
  assign ws  = ws_reg;

  logic [NUM_LINES*SAMPLE_W-1:0] shadow_flat;

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
      logic [SAMPLE_W-1:0] shift_reg;
      logic [SAMPLE_W-1:0] shift_next;
      logic [SAMPLE_W-1:0] shadow_reg;

      assign shift_next = (shift_reg << 1) | SAMPLE_W'(sd_in[gi]);

      // The shadow takes the word including the LSB arriving on this rise.
      always_ff @(posedge HCLK) begin
        if (HRESET || !en) begin
          shift_reg <= '0;
        end else if (capture_bit) begin
          shift_reg <= shift_next;
        end
        if (HRESET) begin
          shadow_reg <= '0;
        end else if (capture_last) begin
          shadow_reg <= shift_next;
        end
      end

      assign shadow_flat[gi*SAMPLE_W +: SAMPLE_W] = shadow_reg;
    end
  endgenerate

  logic              push_active_reg;
  logic [LINE_W-1:0] push_idx_reg;
  logic              push_ws_reg;
  logic              push_fire;
  logic [ENTRY_W-1:0] push_entry;

  always_ff @(posedge HCLK) begin
    if (HRESET || !en) begin
      push_active_reg <= 1'b0;
      push_idx_reg    <= '0;
      push_ws_reg     <= 1'b0;
    end else if (capture_last) begin
      push_active_reg <= !(mono && ws_reg);
      push_idx_reg    <= '0;
      push_ws_reg     <= ws_reg;
    end else if (push_active_reg) begin
      if (push_idx_reg == LINE_W'(NUM_LINES - 1)) begin
        push_active_reg <= 1'b0;
      end else begin
        push_idx_reg <= push_idx_reg + 1'b1;
      end
    end
  end

  // A sequence still pending in a cycle with en low is abandoned, not written.
  assign push_fire  = push_active_reg && en;
  assign push_entry = {shadow_flat[int'(push_idx_reg)*SAMPLE_W +: SAMPLE_W],
                       push_idx_reg, push_ws_reg};

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [LVL_W-1:0]   level_reg;
  logic               overflow_reg;
  logic               full;
  logic               pop;
  logic               accept;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  assign full   = (level_reg == LVL_W'(FIFO_DEPTH));
  assign pop    = (level_reg != '0) && sample_ready;
  assign accept = push_fire && (!full || pop);
  assign drop   = push_fire && full && !pop;

  always_ff @(posedge HCLK) begin
    if (accept) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({accept, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (overflow_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Head fields read as zero while empty so the RAM's unwritten words never show.
  assign head         = mem[rd_ptr_reg];
  assign sample_valid = (level_reg != '0);
  assign {sample_data, sample_line, sample_right} = sample_valid ? head : '0;
  assign level        = level_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_i2s_rx_multi.sv
// Randomised bench for i2s_rx_multi: a time-indexed I2S transmitter/FIFO model
// is compared every cycle, plus hand-computed directed expectations.
`timescale 1ns/1ps
module tb_i2s_rx_multi;
  localparam int NUM_LINES = 2, SAMPLE_W = 24, SLOT_W = 32, CLK_DIV = 2, FIFO_DEPTH = 8;
  localparam int NFR = 16;

  logic HCLK = 1'b0, HRESET = 1'b1, en = 1'b0, mono = 1'b0;
  logic sample_ready = 1'b0, overflow_clr = 1'b0;
  logic [NUM_LINES-1:0] sd_in = '0;
  logic sck, ws, sample_valid, sample_right, overflow;
  logic [SAMPLE_W-1:0] sample_data;
  logic [0:0] sample_line;
  logic [3:0] level;

  i2s_rx_multi #(.NUM_LINES(NUM_LINES), .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W),
                 .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .mono(mono), .sd_in(sd_in),
    .sck(sck), .ws(ws), .sample_data(sample_data), .sample_line(sample_line),
    .sample_right(sample_right), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .level(level), .overflow(overflow),
    .overflow_clr(overflow_clr));

  always #5 HCLK = ~HCLK;

  typedef struct {
    int at;
    logic [SAMPLE_W-1:0] data;
    int line;
    int right;
  } ent_t;

  ent_t sched[$];
  ent_t q[$];
  ent_t popped[$];
  logic [SAMPLE_W-1:0] samp [NFR][2][NUM_LINES];
  int n = 0, ovf_m = 0, base = 0;
  int ready_mode = 0, ready_val = 0, ready_pct = 100, clr_force = 0, clr_rand = 0;
  int passed = 0, total = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_pop(string nm, int i, logic [SAMPLE_W-1:0] d, int l, int r);
    if (popped.size() <= i) begin
      check({nm, " present"}, 64'(popped.size()), 64'(i + 1));
    end else begin
      check({nm, " data"}, 64'(popped[i].data), 64'(d));
      check({nm, " line"}, 64'(popped[i].line), 64'(l));
      check({nm, " right"}, 64'(popped[i].right), 64'(r));
    end
  endtask

  task automatic cycles(int k);
    repeat (k) @(posedge HCLK);
    #1;
  endtask

  // Model: n counts enabled edges; sck, ws and capture instants follow from n alone.
  initial begin : model
    ent_t e, s;
    bit pop, push, full;
    int m, slot;
    forever begin
      @(posedge HCLK);
      if (HRESET) begin
        n = 0; ovf_m = 0; q.delete(); sched.delete();
      end else begin
        pop = (q.size() > 0) && sample_ready;
        push = 0;
        if (en) begin
          n++;
          if (sched.size() > 0 && sched[0].at == n) begin
            e = sched.pop_front();
            push = 1;
          end
          if (n % (2*CLK_DIV) == CLK_DIV) begin
            m = n / (2*CLK_DIV);
            if (m % SLOT_W == SAMPLE_W) begin
              slot = m / SLOT_W;
              if (!(mono && (slot % 2 == 1))) begin
                for (int k = 0; k < NUM_LINES; k++) begin
                  s.at = n + 1 + k;
                  s.data = samp[(base + slot/2) % NFR][slot % 2][k];
                  s.line = k;
                  s.right = slot % 2;
                  sched.push_back(s);
                end
              end
            end
          end
        end else begin
          n = 0;
          sched.delete();
        end
        full = (q.size() == FIFO_DEPTH);
        if (pop) q.delete(0);
        if (push && (!full || pop)) q.push_back(e);
        if (push && full && !pop) ovf_m = 1;
        else if (overflow_clr) ovf_m = 0;
      end
    end
  end

  // Driver: serial data as an I2S transmitter aligned to the model's timeline.
  initial begin : driver
    int nx, m, bc, slot;
    forever begin
      @(posedge HCLK);
      #2;
      case (ready_mode)
        0: sample_ready = ready_val[0];
        1: sample_ready = ($urandom_range(99) < ready_pct);
        default: sample_ready = en && (sched.size() > 0) && (sched[0].at == n + 1)
                                && (q.size() == FIFO_DEPTH);
      endcase
      overflow_clr = (clr_force != 0) || ((clr_rand != 0) && ($urandom_range(63) == 0));
      nx = n + 1;
      m = nx / (2*CLK_DIV);
      bc = m % SLOT_W;
      slot = m / SLOT_W;
      for (int k = 0; k < NUM_LINES; k++) begin
        if (bc >= 1 && bc <= SAMPLE_W)
          sd_in[k] = samp[(base + slot/2) % NFR][slot % 2][k][SAMPLE_W - bc];
        else
          sd_in[k] = 1'($urandom_range(1));
      end
    end
  end

  // Per-cycle comparison against the model, and log of DUT pops.
  initial begin : compare
    logic [33:0] act, exp;
    logic [SAMPLE_W-1:0] ed;
    logic el, er;
    @(posedge HCLK);
    forever begin
      @(negedge HCLK);
      ed = '0; el = 1'b0; er = 1'b0;
      if (q.size() > 0) begin
        ed = q[0].data; el = 1'(q[0].line); er = 1'(q[0].right);
      end
      exp = {1'((n / CLK_DIV) % 2), 1'(((n / (2*CLK_DIV)) / SLOT_W) % 2),
             1'(q.size() > 0), 4'(q.size()), 1'(ovf_m), er, el, ed};
      act = {sck, ws, sample_valid, level, overflow, sample_right, sample_line, sample_data};
      check("cycle {sck,ws,valid,level,ovf,right,line,data}", 64'(act), 64'(exp));
      if (sample_valid && sample_ready) begin
        ent_t p;
        p.at = n; p.data = sample_data; p.line = int'(sample_line); p.right = int'(sample_right);
        popped.push_back(p);
      end
    end
  end

  task automatic do_reset();
    HRESET = 1'b1;
    cycles(2);
    HRESET = 1'b0;
    cycles(1);
  endtask

  initial begin : main
    for (int f = 0; f < NFR; f++)
      for (int c = 0; c < 2; c++)
        for (int l = 0; l < NUM_LINES; l++)
          samp[f][c][l] = SAMPLE_W'($urandom);
    samp[0][0][0] = 24'hA5A5A5; samp[0][1][0] = 24'h5A5A5A;
    samp[0][0][1] = 24'h123456; samp[0][1][1] = 24'hFEDCBA;

    cycles(3);
    HRESET = 1'b0;
    cycles(1);
    check("reset sck", 64'(sck), 0);
    check("reset valid", 64'(sample_valid), 0);
    check("reset level", 64'(level), 0);

    // Reset mid-frame with en high and entries queued.
    en = 1'b1;
    cycles(120);
    check("pre-reset level", 64'(level), 2);
    HRESET = 1'b1;
    cycles(1);
    check("midreset sck", 64'(sck), 0);
    check("midreset ws", 64'(ws), 0);
    check("midreset valid", 64'(sample_valid), 0);
    check("midreset level", 64'(level), 0);
    check("midreset ovf", 64'(overflow), 0);
    cycles(1);
    HRESET = 1'b0; en = 1'b0;
    cycles(2);

    // Stereo capture with ready held high.
    do_reset();
    base = 0; ready_val = 1; popped.delete();
    en = 1'b1;
    cycles(2);   check("sck first rise", 64'(sck), 1);
    cycles(2);   check("sck fall", 64'(sck), 0);
    cycles(2);   check("sck second rise", 64'(sck), 1);
    cycles(121); check("ws left end", 64'(ws), 0);
    cycles(1);   check("ws right start", 64'(ws), 1);
    cycles(127); check("ws right end", 64'(ws), 1);
    cycles(1);   check("ws frame wrap", 64'(ws), 0);
    check_pop("stereo e0", 0, 24'hA5A5A5, 0, 0);
    check_pop("stereo e1", 1, 24'h123456, 1, 0);
    check_pop("stereo e2", 2, 24'h5A5A5A, 0, 1);
    check_pop("stereo e3", 3, 24'hFEDCBA, 1, 1);
    en = 1'b0;
    cycles(2);

    // Mono: right slot produces nothing.
    do_reset();
    mono = 1'b1; ready_val = 0; base = 0;
    en = 1'b1;
    cycles(240);
    check("mono level", 64'(level), 2);
    check("mono head", 64'(sample_data), 64'(24'hA5A5A5));
    ready_mode = 1; ready_pct = 50;
    cycles(600);
    en = 1'b0; ready_mode = 0; mono = 1'b0;
    cycles(2);

    // Overflow with ready low over three frames.
    do_reset();
    ready_val = 0; base = 0;
    en = 1'b1;
    cycles(610);
    check("ovf before 9th level", 64'(level), 8);
    check("ovf before 9th", 64'(overflow), 0);
    cycles(1);
    check("ovf after 9th", 64'(overflow), 1);
    check("ovf after 9th level", 64'(level), 8);
    cycles(169);
    check("ovf 3 frames level", 64'(level), 8);
    check("ovf 3 frames flag", 64'(overflow), 1);
    check("ovf head data", 64'(sample_data), 64'(24'hA5A5A5));
    check("ovf head line", 64'(sample_line), 0);
    check("ovf head right", 64'(sample_right), 0);
    clr_force = 1;
    cycles(1);
    clr_force = 0;
    check("ovf clear pulse", 64'(overflow), 0);
    cycles(85);
    clr_force = 1;
    cycles(1);
    clr_force = 0;
    check("ovf set beats clr", 64'(overflow), 1);
    en = 1'b0;
    cycles(2);

    // Full FIFO with a pop exactly at push cycles.
    do_reset();
    ready_val = 0; base = 0;
    en = 1'b1;
    cycles(484);
    check("fullpop fill level", 64'(level), 8);
    ready_mode = 2;
    cycles(130);
    check("fullpop level", 64'(level), 8);
    check("fullpop ovf", 64'(overflow), 0);
    check("fullpop head", 64'(sample_data), 64'(24'h5A5A5A));
    check("fullpop head right", 64'(sample_right), 1);
    ready_mode = 0;
    en = 1'b0;
    cycles(2);

    // Enable abort mid left slot, then a fresh start.
    do_reset();
    ready_val = 1; base = 2; popped.delete();
    en = 1'b1;
    cycles(41);
    check("abort in left slot", 64'(ws), 0);
    en = 1'b0;
    cycles(1);
    check("abort sck", 64'(sck), 0);
    check("abort ws", 64'(ws), 0);
    check("abort level", 64'(level), 0);
    cycles(4);
    base = 3; popped.delete();
    en = 1'b1;
    cycles(101);
    check("reenable pops", 64'(popped.size()), 2);
    check_pop("reenable e0", 0, samp[3][0][0], 0, 0);
    check_pop("reenable e1", 1, samp[3][0][1], 1, 0);
    en = 1'b0;
    cycles(2);

    // Randomised segments: mono, ready rate, clear pulses and enable drops.
    do_reset();
    for (int f = 0; f < NFR; f++)
      for (int c = 0; c < 2; c++)
        for (int l = 0; l < NUM_LINES; l++)
          samp[f][c][l] = SAMPLE_W'($urandom);
    ready_mode = 1; clr_rand = 1;
    for (int seg = 0; seg < 8; seg++) begin
      base = $urandom_range(NFR - 1);
      mono = 1'($urandom_range(1));
      ready_pct = $urandom_range(15, 100);
      en = 1'b1;
      cycles($urandom_range(200, 1200));
      en = 1'b0;
      cycles($urandom_range(1, 6));
      if (seg == 4) do_reset();
    end
    clr_rand = 0; ready_mode = 0;
    cycles(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
